// File: rtl/encoder_8x3_serial_pkg.sv
// Shared types and constants for the serial 8-to-3 request encoder.
// Optional feature macro: ENC_COUNT_EN (adds the remaining-beat counter).
package enc_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Number of set request bits in a word (0..8).
  function automatic logic [3:0] popcount8(input logic [REQ_W-1:0] w);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < REQ_W; i++) begin
      n = n + {3'b000, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/encoder_8x3_serial_if.sv
// Request/response bundle for the serial encoder.
// slave: the encoder's view; master: the environment driving it.
// Optional feature macro: ENC_COUNT_EN (adds cnt).
interface encoder_8x3_serial_if;
  import enc_pkg::*;

  logic              in_valid;
  logic [REQ_W-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [CODE_W-1:0] out_code;
  logic              out_last;
  logic              out_ready;
  logic              zero_pulse;
`ifdef ENC_COUNT_EN
  logic [3:0]        cnt;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_last, zero_pulse
`ifdef ENC_COUNT_EN
    , output cnt
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_last, zero_pulse
`ifdef ENC_COUNT_EN
    , input cnt
`endif
  );

endinterface

// File: rtl/encoder_8x3_serial_prio_enc.sv
// Combinational lowest-set-bit finder: LSB has the highest priority.
module prio_enc_8x3
  import enc_pkg::*;
(
  input  logic [REQ_W-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Scan from MSB down so the last hit (lowest index) wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    code = '0;
    any  = 1'b0;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (req[i]) begin
        code = CODE_W'(i);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_8x3_serial.sv
// Serial 8-to-3 encoder: accepts a request word, then emits the index of
// each set bit, lowest first, one beat per out_ready handshake.
// Optional feature macro: ENC_COUNT_EN (cnt = beats still to be emitted).
module encoder_8x3_serial
  import enc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  encoder_8x3_serial_if.slave   bus
);

  state_e            state_q, state_d;
  logic [REQ_W-1:0]  pend_q, pend_d;
  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic              out_last_q, out_last_d;
  logic              zero_q, zero_d;
  logic [CODE_W-1:0] nxt_code;
  logic              nxt_any;
`ifdef ENC_COUNT_EN
  logic [3:0]        cnt_q, cnt_d;
`endif

  // The priority search looks at next-state pend so the code is registered
  // and valid in the very cycle EMIT begins.
  prio_enc_8x3 u_prio (
    .req  (pend_d),
    .code (nxt_code),
    .any  (nxt_any)
  );

  // Next-state logic: accept in IDLE, retire one bit per handshake in EMIT.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
`ifdef ENC_COUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_data != '0) begin
            pend_d  = bus.in_data;
            state_d = EMIT;
`ifdef ENC_COUNT_EN
            cnt_d   = popcount8(bus.in_data);
`endif
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          // Clearing the lowest set bit is exactly the bit out_code indexes.
          pend_d = pend_q & (pend_q - 1'b1);
`ifdef ENC_COUNT_EN
          cnt_d  = cnt_q - 4'd1;
`endif
          if (out_last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == EMIT) && nxt_any;
    out_code_d  = out_valid_d ? nxt_code : '0;
    out_last_d  = out_valid_d && ((pend_d & (pend_d - 1'b1)) == '0);
  end

  // State and registered outputs; synchronous reset wins over any handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_last_q  <= 1'b0;
      zero_q      <= 1'b0;
`ifdef ENC_COUNT_EN
      cnt_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_last_q  <= out_last_d;
      zero_q      <= zero_d;
`ifdef ENC_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_code   = out_code_q;
  assign bus.out_last   = out_last_q;
  assign bus.zero_pulse = zero_q;
`ifdef ENC_COUNT_EN
  assign bus.cnt        = cnt_q;
`endif

endmodule

// File: doc/encoder_8x3_serial.md
ENCODER_8X3_SERIAL -- requirements
Module: encoder_8x3_serial

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock and reset ports SHALL be listed first.
REQ-002 clk, input, 1: rising-edge clock for all state.
REQ-003 rst, input, 1: synchronous active-high reset.
REQ-004 in_valid, input, 1: in_data is offered.
REQ-005 in_data, input, 8: request word; each set bit is one request.
REQ-006 in_ready, output, 1: block accepts a word this cycle.
REQ-007 out_valid, output, 1: out_code holds a valid index.
REQ-008 out_code, output, 3: binary index (0..7) of the current request bit.
REQ-009 out_last, output, 1: the current code is the final one for the captured word.
REQ-010 out_ready, input, 1: downstream accepts out_code this cycle.
REQ-011 zero_pulse, output, 1: one-cycle flag for an accepted all-zero word.

Function
REQ-012 The block SHALL have states IDLE and EMIT.
REQ-013 in_ready SHALL be 1 exactly when state is IDLE; there is no accept/emit overlap.
REQ-014 IDLE, in_valid=1, in_data!=0: the block SHALL load pend<=in_data and enter EMIT on the next edge.
REQ-015 IDLE, in_valid=1, in_data==0: the block SHALL stay IDLE, assert zero_pulse for exactly the next cycle, and produce no output beat.
REQ-016 In EMIT, out_valid SHALL be 1, and out_code SHALL be the index of the lowest set bit of pend (LSB-first priority).
REQ-017 Latency SHALL be one cycle from word acceptance to the first out_valid.
REQ-018 out_last SHALL be 1 exactly when pend has one bit set, and 0 whenever out_valid is 0.
REQ-019 When out_valid and out_ready are both 1, the block SHALL clear the indexed bit of pend; if out_last is 1, it SHALL return to IDLE on the same edge.
REQ-020 When out_valid=1 and out_ready=0, out_code, out_last and pend SHALL hold stable; no beat is lost or repeated.
REQ-021 A word with N set bits SHALL yield exactly N beats with strictly ascending codes; sustained out_ready gives one beat per cycle.
REQ-022 in_data=8'hFF SHALL yield codes 0..7 in order, with out_last on code 7.
REQ-023 When state is IDLE, out_valid=0 and out_code=3'b000.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, pend=8'h00, out_valid=0, out_code=0, out_last=0 and zero_pulse=0, giving in_ready=1 after release.
REQ-025 Reset in EMIT SHALL discard remaining requests without emitting them; reset takes priority over all handshakes in the same cycle.

Configuration
REQ-026 With macro ENC_COUNT_EN defined, the block SHALL add output cnt, 4 bits, loaded at acceptance with the popcount of in_data (0..8), decremented on each output handshake, and reset to 0.
REQ-027 Without ENC_COUNT_EN, the cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package enc_pkg SHALL hold the IDLE/EMIT state typedef, REQ_W=8 and CODE_W=3.
REQ-029 The lowest-set-bit search SHALL be a combinational sub-module prio_enc_8x3 (8-bit in; 3-bit code plus any-set flag out), instanced once.

Verification
REQ-030 rst held 2 cycles -> in_ready=1, out_valid=0, out_code=0, zero_pulse=0.
REQ-031 in_data=8'h01 with out_ready=1 -> one beat code=0, out_last=1; in_ready returns to 1 the cycle after the beat.
REQ-032 in_data=8'hA4 with out_ready=1 -> codes 2, 5, 7 on consecutive cycles, with out_last only on 7; with ENC_COUNT_EN, cnt reads 3, 2, 1, then 0.
REQ-033 in_data=8'hFF with out_ready toggling 1,0,1,0 -> codes 0..7 each emitted once, each held stable through the stall cycles.
REQ-034 in_data=8'h00 -> zero_pulse high for one cycle, out_valid stays 0, in_ready stays 1.
REQ-035 in_data=8'h81, rst asserted after code 0 is emitted -> code 7 is never emitted, and the block is in IDLE with pend=0.
